dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..32; DEPTH=1 is a single enabled D flip-flop.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserted when 0.
REQ-005 en  input  1  advance enable; 1 = shift pipeline one stage, 0 = hold.
REQ-006 clr  input  1  synchronous flush of all stages.
REQ-007 d  input  WIDTH  data into stage 0.
REQ-008 d_vld  input  1  qualifies d.
REQ-009 q  output  WIDTH  data from stage DEPTH-1.
REQ-010 q_vld  output  1  valid flag of stage DEPTH-1.
REQ-011 occ  output  $clog2(DEPTH+1)  count of valid stages; present only when DFF_PIPE_OCC_EN is defined.

Function
REQ-012 Each stage SHALL hold a WIDTH-bit data register and a 1-bit valid flag.
REQ-013 On rising clk with rst=1, clr=0, en=1: stage0 SHALL load {d, d_vld}; stage i SHALL load stage i-1 for i=1..DEPTH-1.
REQ-014 On rising clk with rst=1, clr=0, en=0: all stages SHALL hold; d and d_vld ignored.
REQ-015 On rising clk with rst=1, clr=1: all data SHALL clear to 0 and all valid flags to 0, regardless of en, d, d_vld (clr has priority over en).
REQ-016 q and q_vld SHALL be driven directly from stage DEPTH-1 registers; no combinational path from d, d_vld, en or clr to q or q_vld.
REQ-017 Latency: a sample presented with en=1 SHALL appear on q exactly DEPTH en=1 edges later; with en held 1, exactly DEPTH clk cycles.
REQ-018 Data SHALL propagate regardless of d_vld; d_vld only travels alongside as the valid flag.
REQ-019 Stall mid-flight (en=0 for N cycles) SHALL extend latency by exactly N cycles with no data loss or duplication.
REQ-020 en=0 and clr=0 together SHALL leave all state and outputs unchanged.

Reset
REQ-021 When rst=0, all stage data SHALL clear to 0 and all valid flags to 0 immediately, without waiting for clk.
REQ-022 During reset: q=0, q_vld=0, occ=0 (when present).
REQ-023 Reset asserted mid-operation SHALL discard all in-flight samples; none SHALL appear on q after release.
REQ-024 The first rising clk after rst returns to 1 SHALL follow REQ-013..REQ-015 normally.

Configuration
REQ-025 Macro DFF_PIPE_OCC_EN: when defined, port occ and a registered occupancy counter SHALL be compiled in.
REQ-026 With DFF_PIPE_OCC_EN: on en=1 edge, occ SHALL update to occ + d_vld - q_vld (q_vld as before the edge); on clr edge occ SHALL become 0; on en=0 occ SHALL hold.
REQ-027 With DFF_PIPE_OCC_EN: occ SHALL always equal the number of set stage valid flags and never exceed DEPTH.
REQ-028 Without DFF_PIPE_OCC_EN: port occ and the counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 WIDTH=8, DEPTH=4, en=1; drive d=0xA1,0xB2,0xC3,0xD4 with d_vld=1 on 4 consecutive cycles -> q shows 0xA1..0xD4 with q_vld=1 on cycles 4..7, then q_vld=0.
REQ-030 DEPTH=4: send 0x11, hold en=0 for 3 cycles after second edge -> 0x11 appears on q at cycle 7, exactly once.
REQ-031 Fill pipe with 4 valid samples, assert clr=1 with en=1 for one edge -> q=0, q_vld=0, occ=0 next cycle; no earlier sample ever emerges.
REQ-032 Pull rst=0 between clk edges with 3 valid samples in flight -> q=0, q_vld=0 before next clk edge; no samples after release.
REQ-033 DFF_PIPE_OCC_EN defined, DEPTH=4: valid on 6 consecutive cycles -> occ 1,2,3,4,4,4; then d_vld=0 -> occ 3,2,1,0.
REQ-034 DEPTH=1, WIDTH=1, en=1: toggle d at 10 ns period offsets -> q equals d sampled at previous rising clk.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: enabled, flushable multi-stage register pipeline with valid flags.
//
// Each stage holds a WIDTH-bit data word and a valid bit. When en is high the
// pipe shifts one stage (stage 0 takes {d, d_vld}); when en is low everything
// holds. clr synchronously empties the pipe and wins over en. rst is
// asynchronous and active-low.
//
// Optional feature (macro DFF_PIPE_OCC_EN): adds the occ port, a registered
// count of valid stages.
//
// Parameters:
//   WIDTH  data width, 1..64
//   DEPTH  number of stages, 1..32 (1 = a single enabled flop)
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous reset, active-low
//   en     advance enable
//   clr    synchronous flush
//   d      data into stage 0
//   d_vld  valid qualifier for d
//   q      data of the last stage
//   q_vld  valid flag of the last stage
//   occ    number of valid stages (only with DFF_PIPE_OCC_EN)
module dff_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  // Stage storage: index 0 is the input stage, DEPTH-1 drives the outputs.
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Stage 0 capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q[0] <= '0;
      vld_q[0]  <= 1'b0;
    end else if (clr) begin
      data_q[0] <= '0;
      vld_q[0]  <= 1'b0;
    end else if (en) begin
      data_q[0] <= d;
      vld_q[0]  <= d_vld;
    end
  end

  // Stages 1..DEPTH-1 shift from their predecessor; absent when DEPTH is 1.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q[gi] <= '0;
        vld_q[gi]  <= 1'b0;
      end else if (clr) begin
        data_q[gi] <= '0;
        vld_q[gi]  <= 1'b0;
      end else if (en) begin
        data_q[gi] <= data_q[gi-1];
        vld_q[gi]  <= vld_q[gi-1];
      end
    end
  end

  // Outputs come straight from the last stage's flops.
  assign q     = data_q[DEPTH-1];
  assign q_vld = vld_q[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;

  // One sample enters and one leaves per shift, so the net change is
  // d_vld minus the valid bit being pushed out of the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (clr) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + OCC_W'(d_vld) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: self-checking bench for dff_pipe.
// Main instance WIDTH=8/DEPTH=4, plus a WIDTH=1/DEPTH=1 instance. Reference
// model: a queue of the last DEPTH accepted {vld,data} samples.
module tb_dff_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned DP = 4;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] data;
  } ent_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         clr;
  logic [W-1:0] d;
  logic         d_vld;
  logic [W-1:0] q;
  logic         q_vld;

  logic         d1;
  logic         d1_vld;
  logic         q1;
  logic         q1_vld;

`ifdef DFF_PIPE_OCC_EN
  logic [$clog2(DP+1)-1:0] occ;
  logic                    occ1;
`endif

  dff_pipe #(.WIDTH(W), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .d     (d),
    .d_vld (d_vld),
    .q     (q),
    .q_vld (q_vld)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ   (occ)
`endif
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .clr   (1'b0),
    .d     (d1),
    .d_vld (d1_vld),
    .q     (q1),
    .q_vld (q1_vld)
`ifdef DFF_PIPE_OCC_EN
    ,
    .occ   (occ1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   vectors;
  int   miscompares;
  ent_t pipe [$];
  logic exp_q1;
  logic exp_q1_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(DP); i++) pipe.push_back('0);
    exp_q1     = 1'b0;
    exp_q1_vld = 1'b0;
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (pipe[i]) if (pipe[i].vld) n++;
    return n;
  endfunction

  // Apply the rules for one rising edge using the inputs present at it.
  task automatic model_step();
    ent_t e;
    if (clr) begin
      pipe.delete();
      for (int i = 0; i < int'(DP); i++) pipe.push_back('0);
    end else if (en) begin
      e.vld  = d_vld;
      e.data = d;
      pipe.push_back(e);
      void'(pipe.pop_front());
    end
    exp_q1     = d1;
    exp_q1_vld = d1_vld;
  endtask

  task automatic check_outputs();
    check("q", 64'(q), 64'(pipe[0].data));
    check("q_vld", 64'(q_vld), 64'(pipe[0].vld));
    check("q1", 64'(q1), 64'(exp_q1));
    check("q1_vld", 64'(q1_vld), 64'(exp_q1_vld));
`ifdef DFF_PIPE_OCC_EN
    check("occ", 64'(occ), 64'(model_occ()));
    check("occ1", 64'(occ1), 64'(exp_q1_vld));
`endif
  endtask

  // One clock: edge, model update, sample 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic e, input logic c, input logic [W-1:0] dd, input logic v);
    en    = e;
    clr   = c;
    d     = dd;
    d_vld = v;
    d1     = ~d1;
    d1_vld = 1'($urandom_range(0, 1));
  endtask

  logic [W-1:0] seq_a [4];
  int           hits;
  int           hit_cycle;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; d = '0; d_vld = 1'b0;
    d1 = 1'b0; d1_vld = 1'b0;
    model_reset();
    #7;
    check_outputs();
    check("rst_q", 64'(q), 64'd0);
    #1 rst = 1'b1;
    #8;

    // Four back-to-back valid samples then bubbles.
    seq_a[0] = 8'hA1; seq_a[1] = 8'hB2; seq_a[2] = 8'hC3; seq_a[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, seq_a[i], 1'b1);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      cycle();
      if (i < 3) check("seq_q", 64'(q), 64'(seq_a[i+1]));
    end

    // Stall mid-flight: 0x11 must emerge exactly once, on the 7th edge.
    drive(1'b1, 1'b1, '0, 1'b0);
    cycle();
    hits = 0;
    hit_cycle = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) drive(1'b1, 1'b0, 8'h11, 1'b1);
      else if (c >= 3 && c <= 5) drive(1'b0, 1'b0, $urandom_range(0, 255), 1'b1);
      else drive(1'b1, 1'b0, '0, 1'b0);
      cycle();
      if (q_vld && q == 8'h11) begin
        hits++;
        hit_cycle = c;
      end
    end
    check("stall_hits", 64'(hits), 64'd1);
    check("stall_cycle", 64'(hit_cycle), 64'd7);

    // Full pipe then flush with en=1: nothing valid emerges afterwards.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'b1);
      cycle();
    end
    drive(1'b1, 1'b1, 8'hEE, 1'b1);
    cycle();
    check("clr_q_vld", 64'(q_vld), 64'd0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      cycle();
      if (q_vld) hits++;
    end
    check("clr_leak", 64'(hits), 64'd0);

    // Asynchronous reset between edges with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, W'($urandom), 1'b1);
      cycle();
    end
    #2 rst = 1'b0;
    #1;
    check("arst_q", 64'(q), 64'd0);
    check("arst_q_vld", 64'(q_vld), 64'd0);
    model_reset();
    check_outputs();
    #1 rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      cycle();
      if (q_vld) hits++;
    end
    check("arst_leak", 64'(hits), 64'd0);

`ifdef DFF_PIPE_OCC_EN
    // Occupancy ramp: fill to saturation, then drain.
    begin
      int exp_occ [10] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
      for (int i = 0; i < 10; i++) begin
        drive(1'b1, 1'b0, W'($urandom), (i < 6) ? 1'b1 : 1'b0);
        cycle();
        check("occ_ramp", 64'(occ), 64'(exp_occ[i]));
      end
    end
`endif

    // Randomised traffic with occasional flush and asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
            W'($urandom), 1'($urandom_range(0, 1)));
      cycle();
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1 rst = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
